// File: rtl/pipelined_rca_if.sv
`timescale 1ns/1ps
// Operand/result bundle for pipelined_rca: valid/ready operand channel in, valid/ready result channel out.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry it; master = producer+consumer side, slave = the adder.
//
// Signals:
//   in_valid/in_ready/a/b/cin      operand channel (master -> slave, ready back)
//   out_valid/out_ready/sum/cout   result channel (slave -> master, ready forward)
//   ovf                            signed overflow, present only with PIPELINED_RCA_OVF_EN
interface pipelined_rca_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef PIPELINED_RCA_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipelined_rca.sv
`timescale 1ns/1ps
// Pipelined ripple-carry adder: WIDTH-bit a+b+cin split into STAGES chunks, one chunk added per stage.
// Latency: STAGES cycles from operand transfer to out_valid; throughput one add per cycle.
// Backpressure: full valid/ready; empty stages keep accepting under a downstream stall, results held stable.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   bus (slave)  in_valid/in_ready/a/b/cin operand channel, out_valid/out_ready/sum/cout result channel
// Optional feature macro: PIPELINED_RCA_OVF_EN adds bus.ovf (signed overflow, pipelined with sum).
module pipelined_rca #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pipelined_rca_if.slave bus
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  generate
    if (STAGES < 1) begin : g_bad_stages
      $error("pipelined_rca: STAGES must be >= 1");
    end else if ((WIDTH % STAGES) != 0) begin : g_bad_width
      $error("pipelined_rca: WIDTH must be a multiple of STAGES");
    end
  endgenerate

  // Per-stage state. Stage k holds the finished low chunks 0..k in s_q[k], the carry out of
  // chunk k in c_q[k], and the raw operands in pa_q/pb_q so later stages can pick their chunk.
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic [WIDTH-1:0]  pa_q [STAGES];
  logic [WIDTH-1:0]  pa_d [STAGES];
  logic [WIDTH-1:0]  pb_q [STAGES];
  logic [WIDTH-1:0]  pb_d [STAGES];

  // What each stage would load: the input port for stage 0, the previous stage otherwise.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;

  // adv[k]: stage k loads this cycle. adv[STAGES] is the consumer taking the result.
  logic [STAGES:0]   adv;

`ifdef PIPELINED_RCA_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Advance chain, evaluated from the output back to the input so a pop at the tail lets every
  // full stage shift in the same cycle; an empty stage loads whatever the downstream state.
  always_comb begin : p_adv
    adv         = '0;
    adv[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 1; k--) begin
      adv[k] = v_q[k-1] & (~v_q[k] | adv[k+1]);
    end
    adv[0] = bus.in_valid & (~v_q[0] | adv[1]);
  end

  assign bus.in_ready = ~v_q[0] | adv[1];

  always_comb begin : p_src
    src_a[0] = bus.a;
    src_b[0] = bus.b;
    src_s[0] = '0;
    src_c    = '0;
    src_c[0] = bus.cin;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = pa_q[k-1];
      src_b[k] = pb_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  always_comb begin : p_stage
    logic [CHUNK:0] part;
    part = '0;
    v_d  = v_q;
    c_d  = c_q;
    for (int k = 0; k < STAGES; k++) begin
      s_d[k]  = s_q[k];
      pa_d[k] = pa_q[k];
      pb_d[k] = pb_q[k];

      // A stage stays full unless it hands its op on; it becomes full whenever it loads.
      v_d[k] = adv[k] | (v_q[k] & ~adv[k+1]);

      // One CHUNK-wide add with the incoming carry; its top bit is the carry to the next stage.
      part = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
           + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, src_c[k]};

      if (adv[k]) begin
        s_d[k]                  = src_s[k];
        s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
        c_d[k]                  = part[CHUNK];
        pa_d[k]                 = src_a[k];
        pb_d[k]                 = src_b[k];
      end
    end

`ifdef PIPELINED_RCA_OVF_EN
    // Carry into the MSB is recovered as a^b^sum at that bit; overflow is it XOR carry out.
    ovf_d = ovf_q;
    if (adv[LAST]) begin
      ovf_d = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        s_q[k]  <= '0;
        pa_q[k] <= '0;
        pb_q[k] <= '0;
      end
`ifdef PIPELINED_RCA_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        s_q[k]  <= s_d[k];
        pa_q[k] <= pa_d[k];
        pb_q[k] <= pb_d[k];
      end
`ifdef PIPELINED_RCA_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  // Outputs come straight from last-stage flops: no combinational path from a/b to sum.
  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.cout      = c_q[LAST];
`ifdef PIPELINED_RCA_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

  // A presented result must not change until the consumer takes it.
  a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.sum) && $stable(bus.cout)));

endmodule

// File: tb/tb_pipelined_rca.sv
`timescale 1ns/1ps
// Self-checking bench for pipelined_rca: directed 8-bit/4-stage scenarios plus random 32-bit runs at 1, 4, 8 stages.
// Latency: directed checks measure the 4-cycle latency; scoreboards check order and values.
// Backpressure: random valid/ready toggling on the random instances; directed stall and drain on the 8-bit one.
module tb_pipelined_rca;

  typedef struct {
    longint unsigned s;
    bit              c;
    bit              o;
  } exp_t;

  localparam int N_RAND = 10000;

  int n_tests   = 0;
  int n_fail    = 0;
  int rand_done = 0;
  int pops8     = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_r_n;

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int w, input longint unsigned a, input longint unsigned b, input bit cin);
    exp_t            r;
    longint unsigned t;
    longint          lim, sa, sb, st;
    t    = a + b + 64'(cin);
    r.s  = t & ((64'd1 << w) - 64'd1);
    r.c  = ((t >> w) & 64'd1) != 64'd0;
    lim  = longint'(1) << (w - 1);
    sa   = (((a >> (w - 1)) & 64'd1) != 64'd0) ? longint'(a) - (lim << 1) : longint'(a);
    sb   = (((b >> (w - 1)) & 64'd1) != 64'd0) ? longint'(b) - (lim << 1) : longint'(b);
    st   = sa + sb + longint'(cin);
    r.o  = (st >= lim) || (st < -lim);
    return r;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed 8-bit / 4-stage instance ----------------
  pipelined_rca_if #(.WIDTH(8)) bus8 ();
  pipelined_rca #(.WIDTH(8), .STAGES(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  exp_t q8[$];

  initial begin : mon8
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus8.out_valid && bus8.out_ready) begin
        if (q8.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL w8_unexpected_out: got sum 0x%0h, expected no result at %0t", bus8.sum, $time);
        end else begin
          e = q8.pop_front();
          chk("w8_sum", bus8.sum, e.s);
          chk("w8_cout", bus8.cout, e.c);
`ifdef PIPELINED_RCA_OVF_EN
          chk("w8_ovf", bus8.ovf, e.o);
`endif
          pops8++;
        end
      end
    end
  end

  // Present one op, wait (bounded) for acceptance, record expected result on transfer.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.in_valid = 1'b1;
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = c;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus8.in_ready) begin
        q8.push_back(model(8, a, b, c));
        tick();
        return;
      end
      tick();
    end
    n_tests++;
    n_fail++;
    $display("FAIL w8_accept_timeout: got in_ready 0 for 50 cycles, expected 1");
  endtask

  // ---------------- random 32-bit instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int S = (g == 0) ? 1 : ((g == 1) ? 4 : 8);

    pipelined_rca_if #(.WIDTH(32)) bus ();
    pipelined_rca #(.WIDTH(32), .STAGES(S)) dut (.clk(clk), .rst_n(rst_r_n), .bus(bus));

    exp_t q[$];

    initial begin : drv
      int          sent;
      bit          pend;
      logic [31:0] ra, rb;
      logic        rc;
      sent = 0;
      pend = 1'b0;
      ra   = '0;
      rb   = '0;
      rc   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge rst_r_n);
      tick();
      while (sent < N_RAND) begin
        if (!pend && $urandom_range(0, 3) != 0) begin
          ra   = $urandom;
          rb   = $urandom;
          rc   = 1'($urandom);
          pend = 1'b1;
        end
        bus.in_valid  = pend;
        bus.a         = ra;
        bus.b         = rb;
        bus.cin       = rc;
        bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (bus.in_valid && bus.in_ready) begin
          q.push_back(model(32, ra, rb, rc));
          pend = 1'b0;
          sent++;
        end
        tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 200 && q.size() != 0; i++) tick();
      chk($sformatf("rand_s%0d_drained_left", S), q.size(), 0);
      rand_done++;
    end

    initial begin : mon
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst_r_n && bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rand_s%0d_unexpected_out: got sum 0x%0h, expected no result", S, bus.sum);
          end else begin
            e = q.pop_front();
            chk($sformatf("rand_s%0d_sum", S), bus.sum, e.s);
            chk($sformatf("rand_s%0d_cout", S), bus.cout, e.c);
`ifdef PIPELINED_RCA_OVF_EN
            chk($sformatf("rand_s%0d_ovf", S), bus.ovf, e.o);
`endif
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [7:0] ba [6];
    logic [7:0] bb [6];
    logic       bc [6];
    exp_t       e0;
    int         n;
    int         p0;

    rst_n   = 1'b0;
    rst_r_n = 1'b0;

    // Reset holds outputs idle regardless of inputs.
    for (int i = 0; i < 3; i++) begin
      bus8.in_valid  = 1'b1;
      bus8.a         = 8'($urandom);
      bus8.b         = 8'($urandom);
      bus8.cin       = 1'($urandom);
      bus8.out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_out_valid", bus8.out_valid, 0);
      chk("rst_sum", bus8.sum, 0);
      chk("rst_cout", bus8.cout, 0);
      chk("rst_in_ready", bus8.in_ready, 1);
    end
    #2;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    rst_n          = 1'b1;
    rst_r_n        = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("idle_out_valid", bus8.out_valid, 0);
      chk("idle_in_ready", bus8.in_ready, 1);
    end
    tick();

    // Single op latency and value.
    issue8(8'h3C, 8'h0F, 1'b1);
    bus8.in_valid = 1'b0;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus8.out_valid) break;
      n++;
      tick();
    end
    chk("single_latency", n, 4);
    chk("single_sum", bus8.sum, 8'h4C);
    chk("single_cout", bus8.cout, 0);
    repeat (3) tick();

    // Wrap-around and signed overflow cases.
    issue8(8'hFF, 8'h00, 1'b1);
    issue8(8'h7F, 8'h01, 1'b0);
    issue8(8'h80, 8'h80, 1'b0);
    bus8.in_valid = 1'b0;
    repeat (8) tick();
    chk("wrap_queue_empty", q8.size(), 0);

    // Back-to-back with a stall from cycle 3, then drain.
    for (int i = 0; i < 6; i++) begin
      ba[i] = 8'($urandom);
      bb[i] = 8'($urandom);
      bc[i] = 1'($urandom);
    end
    e0 = model(8, ba[0], bb[0], bc[0]);
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) issue8(ba[i], bb[i], bc[i]);
    bus8.out_ready = 1'b0;
    issue8(ba[3], bb[3], bc[3]);
    bus8.in_valid = 1'b1;
    bus8.a        = ba[4];
    bus8.b        = bb[4];
    bus8.cin      = bc[4];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", bus8.in_ready, 0);
      chk("stall_out_valid", bus8.out_valid, 1);
      chk("stall_sum_held", bus8.sum, e0.s);
      chk("stall_cout_held", bus8.cout, e0.c);
      tick();
    end
    bus8.out_ready = 1'b1;
    p0 = pops8;
    issue8(ba[4], bb[4], bc[4]);
    issue8(ba[5], bb[5], bc[5]);
    bus8.in_valid = 1'b0;
    repeat (4) tick();
    chk("drain_one_per_cycle", pops8 - p0, 6);
    repeat (2) tick();

    // Async reset with ops in flight.
    bus8.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue8(8'($urandom), 8'($urandom), 1'($urandom));
    bus8.in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("inflight_out_valid", bus8.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus8.out_valid, 0);
    chk("async_rst_sum", bus8.sum, 0);
    chk("async_rst_in_ready", bus8.in_ready, 1);
    q8.delete();
    @(posedge clk);
    #2;
    rst_n          = 1'b1;
    bus8.out_ready = 1'b1;
    p0             = pops8;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_output", bus8.out_valid, 0);
      tick();
    end
    chk("post_rst_pop_count", pops8 - p0, 0);

    // Wait (bounded) for the random instances.
    for (int i = 0; i < 60000 && rand_done < 3; i++) @(posedge clk);
    if (rand_done < 3) begin
      n_tests++;
      n_fail++;
      $display("FAIL rand_timeout: got %0d instances finished, expected 3", rand_done);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
